// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer block and its bench.
package bit_serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage : bit_serializer_pkg

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word hold register, so that the
// next word can wait while the current one shifts out with no gap.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  ser_state_t       state_q,     state_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;

  logic accept;
  logic load;
  logic at_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      shift_reg_q <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      shift_reg_q <= shift_reg_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    shift_reg_d = shift_reg_q;
    bit_cnt_d   = bit_cnt_q;

    at_last = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
    // Accept only into an empty hold; load only from a full one, so the two
    // never fire together and the hold updates below cannot conflict.
    accept  = data_valid && !hold_full_q;
    load    = hold_full_q && ((state_q == IDLE) || (bit_cnt_q == LAST_BIT));

    if (accept) begin
      hold_data_d = data_in;
      hold_full_d = 1'b1;
    end

    if (load) begin
      shift_reg_d = hold_data_q;
      bit_cnt_d   = '0;
      state_d     = SHIFT;
      hold_full_d = 1'b0;
    end else if (state_q == SHIFT) begin
      if (bit_cnt_q != LAST_BIT) begin
        shift_reg_d = MSB_FIRST ? {shift_reg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shift_reg_q[WIDTH-1:1]};
        bit_cnt_d   = bit_cnt_q + CNT_W'(1);
      end else begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    end
  end

  assign data_ready = !hold_full_q;
  assign ser_valid  = (state_q == SHIFT);
  assign word_done  = at_last;
  assign ser_out    = (state_q == SHIFT) &&
                      (MSB_FIRST ? shift_reg_q[WIDTH-1] : shift_reg_q[0]);

endmodule : bit_serializer
